// File: rtl/fft_pkg.sv
// fft_pkg: shared helpers for the FFT back-end blocks.
package fft_pkg;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cplx_pow2.sv
// cplx_pow2: squaring (S2) and summing (S3) stages of the power pipeline, stallable.
module cplx_pow2 #(
  parameter int S_WIDTH = 32,
  parameter int P_WIDTH = 2*S_WIDTH+1,
  parameter int CW = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      i_en,
  input  logic                      i_vld,
  input  logic signed [S_WIDTH-1:0] i_re,
  input  logic signed [S_WIDTH-1:0] i_im,
  input  logic [CW-1:0]             i_chan,
  input  logic                      i_last,
  output logic [P_WIDTH-1:0]        pwr_o,
  output logic [CW-1:0]             chan_o,
  output logic                      last_o,
  output logic                      valid_o
);
  logic signed [2*S_WIDTH-1:0] r_sq_re, r_sq_im;
  logic [CW-1:0]               r_s2_chan;
  logic                        r_s2_last, r_s2_vld;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sq_re   <= '0;
      r_sq_im   <= '0;
      r_s2_chan <= '0;
      r_s2_last <= 1'b0;
      r_s2_vld  <= 1'b0;
      pwr_o     <= '0;
      chan_o    <= '0;
      last_o    <= 1'b0;
      valid_o   <= 1'b0;
    end else if (i_en) begin
      r_sq_re   <= (2*S_WIDTH)'(i_re) * (2*S_WIDTH)'(i_re);
      r_sq_im   <= (2*S_WIDTH)'(i_im) * (2*S_WIDTH)'(i_im);
      r_s2_chan <= i_chan;
      r_s2_last <= i_last;
      r_s2_vld  <= i_vld;
      // squares are non-negative, so zero-extension keeps full precision
      pwr_o     <= P_WIDTH'($unsigned(r_sq_re)) + P_WIDTH'($unsigned(r_sq_im));
      chan_o    <= r_s2_chan;
      last_o    <= r_s2_last;
      valid_o   <= r_s2_vld;
    end
  end
endmodule

// File: rtl/fft_power_serializer.sv
// fft_power_serializer: ping-pong frame capture, per-channel issue and power streaming
// over valid/ready with sticky overflow on dropped frames.
module fft_power_serializer
  import fft_pkg::*;
#(
  parameter int S_WIDTH = 32,
  parameter int CHANELS = 2,
  parameter int P_WIDTH = 2*S_WIDTH+1,
  localparam int CW = clog2_min1(CHANELS)
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         frame_vld_i,
  input  logic [CHANELS*S_WIDTH-1:0]   re_i,
  input  logic [CHANELS*S_WIDTH-1:0]   im_i,
  output logic [P_WIDTH-1:0]           pwr_o,
  output logic [CW-1:0]                chan_o,
  output logic                         last_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         ovf_o
);
  typedef enum logic {IDLE, RUN} state_t;
  logic [CHANELS-1:0][S_WIDTH-1:0] r_buf_re [2];
  logic [CHANELS-1:0][S_WIDTH-1:0] r_buf_im [2];
  logic                        r_wr_ptr, r_rd_ptr, r_ovf;
  logic [1:0]                  r_cnt, w_cnt_nxt;
  logic [CW-1:0]               r_idx;
  state_t                      r_state, w_state_nxt;
  logic                        w_adv, w_issue, w_rel, w_cap;
  logic signed [S_WIDTH-1:0]   r_s1_re, r_s1_im;
  logic [CW-1:0]               r_s1_chan;
  logic                        r_s1_last, r_s1_vld;
  always_comb begin
    w_adv       = !(valid_o && !ready_i);
    w_issue     = w_adv && (r_state == RUN || r_cnt != 2'd0);
    w_rel       = w_issue && r_idx == CW'(CHANELS-1);
    // a full buffer still accepts a frame when its oldest slot frees this cycle
    w_cap       = frame_vld_i && (r_cnt != 2'd2 || w_rel);
    w_cnt_nxt   = r_cnt + {1'b0, w_cap} - {1'b0, w_rel};
    w_state_nxt = (w_cnt_nxt != 2'd0) ? RUN : IDLE;
  end
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_buf_re[r_wr_ptr] <= re_i;
      r_buf_im[r_wr_ptr] <= im_i;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_cnt     <= 2'd0;
      r_idx     <= '0;
      r_state   <= IDLE;
      r_ovf     <= 1'b0;
      r_s1_re   <= '0;
      r_s1_im   <= '0;
      r_s1_chan <= '0;
      r_s1_last <= 1'b0;
      r_s1_vld  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_state <= w_state_nxt;
      if (w_cap) r_wr_ptr <= ~r_wr_ptr;
      if (w_rel) r_rd_ptr <= ~r_rd_ptr;
      if (w_issue) r_idx <= w_rel ? '0 : r_idx + CW'(1);
      if (frame_vld_i && !w_cap) r_ovf <= 1'b1;
      if (w_adv) begin
        r_s1_vld  <= w_issue;
        r_s1_re   <= r_buf_re[r_rd_ptr][r_idx];
        r_s1_im   <= r_buf_im[r_rd_ptr][r_idx];
        r_s1_chan <= r_idx;
        r_s1_last <= r_idx == CW'(CHANELS-1);
      end
    end
  end
  assign ovf_o = r_ovf;
  cplx_pow2 #(.S_WIDTH(S_WIDTH), .P_WIDTH(P_WIDTH), .CW(CW)) u_pow (
    .clk     (clk),
    .rstn    (rstn),
    .i_en    (w_adv),
    .i_vld   (r_s1_vld),
    .i_re    (r_s1_re),
    .i_im    (r_s1_im),
    .i_chan  (r_s1_chan),
    .i_last  (r_s1_last),
    .pwr_o   (pwr_o),
    .chan_o  (chan_o),
    .last_o  (last_o),
    .valid_o (valid_o)
  );
endmodule

// File: tb/tb_fft_power_serializer.sv
// tb_fft_power_serializer: directed checks of latency, arithmetic, back-pressure,
// overflow and reset behaviour.
module tb_fft_power_serializer;
  localparam int P = 65;
  logic clk = 1'b0, rstn = 1'b0, frame_vld_i = 1'b0, ready_i = 1'b1;
  logic [63:0] re_i = '0, im_i = '0;
  logic [P-1:0] pwr_o;
  logic chan_o, last_o, valid_o, ovf_o;
  int passed = 0, failed = 0, total = 0, nb;
  logic [P-1:0] q[$];
  always #5 clk = ~clk;
  fft_power_serializer #(.S_WIDTH(32), .CHANELS(2)) dut (
    .clk(clk), .rstn(rstn), .frame_vld_i(frame_vld_i), .re_i(re_i), .im_i(im_i),
    .pwr_o(pwr_o), .chan_o(chan_o), .last_o(last_o), .valid_o(valid_o),
    .ready_i(ready_i), .ovf_o(ovf_o)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [P-1:0] obs, input logic [P-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic set_frame(input logic signed [31:0] r0, r1, i0, i1);
    re_i = {r1, r0};
    im_i = {i1, i0};
  endtask
  task automatic strobe();
    frame_vld_i = 1'b1;
    tick();
    frame_vld_i = 1'b0;
  endtask
  task automatic wait_valid(input string tag);
    for (int i = 0; i < 10 && valid_o !== 1'b1; i++) tick();
    chk(tag, valid_o, 1);
  endtask
  task automatic beat(input string tag, input logic [P-1:0] p, input logic c, input logic l);
    chk({tag, "_vld"}, valid_o, 1);
    chk({tag, "_pwr"}, pwr_o, p);
    chk({tag, "_chan"}, chan_o, c);
    chk({tag, "_last"}, last_o, l);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_vld", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_pwr", pwr_o, 0);
    chk("rst_chan", chan_o, 0);
    rstn = 1'b1;
    tick();
    set_frame(3, -4, 4, 3);
    strobe();
    chk("t1_lat1", valid_o, 0);
    tick();
    tick();
    chk("t1_lat3", valid_o, 0);
    tick();
    beat("t1_b0", 25, 0, 0);
    tick();
    beat("t1_b1", 25, 1, 1);
    tick();
    chk("t1_idle", valid_o, 0);
    chk("t1_ovf", ovf_o, 0);
    set_frame(32'sh8000_0000, 5, 32'sh8000_0000, -7);
    strobe();
    wait_valid("t2_wait");
    chk("t2_pwr", pwr_o, 65'h0_8000_0000_0000_0000);
    chk("t2_msb", pwr_o[64], 0);
    tick();
    beat("t2_b1", 74, 1, 1);
    tick();
    ready_i = 1'b0;
    set_frame(6, 1, 8, 1);
    strobe();
    wait_valid("t3_wait");
    repeat (10) tick();
    beat("t3_hold", 100, 0, 0);
    ready_i = 1'b1;
    tick();
    beat("t3_b1", 2, 1, 1);
    tick();
    chk("t3_idle", valid_o, 0);
    for (int j = 0; j <= 10; j++) begin
      frame_vld_i = (j % 2 == 0) && j < 8;
      if (frame_vld_i) set_frame(j/2 + 1, 0, 0, j/2 + 2);
      tick();
      if (j >= 3) begin
        int b, k;
        b = j - 3;
        k = b / 2 + 1;
        beat($sformatf("t5b_b%0d", b), (b % 2) ? (k+1)*(k+1) : k*k, b % 2, b % 2);
      end
    end
    frame_vld_i = 1'b0;
    tick();
    chk("t5b_idle", valid_o, 0);
    chk("t5b_ovf", ovf_o, 0);
    ready_i = 1'b0;
    set_frame(1, 2, 0, 0);
    strobe();
    wait_valid("t4_wait");
    frame_vld_i = 1'b1;
    set_frame(3, 0, 0, 1);
    tick();
    set_frame(4, 0, 0, 3);
    tick();
    set_frame(7, 7, 7, 7);
    tick();
    frame_vld_i = 1'b0;
    chk("t4_ovf", ovf_o, 1);
    beat("t4_hold", 1, 0, 0);
    ready_i = 1'b1;
    tick();
    beat("t4_a1", 4, 1, 1);
    q.delete();
    repeat (12) begin
      tick();
      if (valid_o) q.push_back(pwr_o);
    end
    chk("t4_nbeats", q.size(), 4);
    chk("t4_q0", q.size() > 0 ? q[0] : 'x, 9);
    chk("t4_q1", q.size() > 1 ? q[1] : 'x, 1);
    chk("t4_q2", q.size() > 2 ? q[2] : 'x, 16);
    chk("t4_q3", q.size() > 3 ? q[3] : 'x, 9);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("t5a_ovf0", ovf_o, 0);
    set_frame(1, 1, 1, 1);
    frame_vld_i = 1'b1;
    repeat (8) tick();
    frame_vld_i = 1'b0;
    chk("t5a_ovf", ovf_o, 1);
    repeat (12) tick();
    set_frame(5, 5, 5, 5);
    strobe();
    wait_valid("t6_wait");
    chk("t6_pwr", pwr_o, 50);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("t6_vld", valid_o, 0);
    chk("t6_ovf", ovf_o, 0);
    chk("t6_pwr0", pwr_o, 0);
    nb = 0;
    repeat (6) begin
      tick();
      if (valid_o) nb++;
    end
    chk("t6_nolate", nb, 0);
    set_frame(1, 2, 0, 0);
    strobe();
    wait_valid("t6_wait2");
    beat("t6_b0", 1, 0, 0);
    tick();
    beat("t6_b1", 4, 1, 1);
    tick();
    chk("t6_idle", valid_o, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
